// File: rtl/rwire_arb_pkg.sv
// Shared definitions for the RWire round-robin arbiter: state encoding and
// the constant function that sizes the lock idle counter.
package rwire_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Bits needed to hold the value 'limit' (ceil(log2(limit+1))), never below 1.
  function automatic int cnt_bits(input int limit);
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) > limit) return b;
    end
    return 31;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set bit of req scanning ptr, ptr+1, ... mod n.
// Purely combinational, zero latency; no backpressure of its own.
// ptr is always < n, so the wrapped index never leaves the req range.
module rr_pick #(
  parameter int n    = 4,
  parameter int srcw = 2
) (
  input  logic [n-1:0]    req,
  input  logic [srcw-1:0] ptr,
  output logic            found,
  output logic [srcw-1:0] idx
);

  int              c;
  logic [srcw-1:0] cand;

  // Scan from the farthest offset down so the closest-to-ptr request wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int k = n - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      cand = srcw'(c);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rwire_rr_arbiter.sv
// Round-robin arbiter sharing one registered value/valid channel among n requesters.
// Latency: GRANT combinational, output register valid the cycle after the grant.
// Backpressure: OUT_HAS && !OUT_RDY holds the output register and suppresses all grants.
module rwire_rr_arbiter
  import rwire_arb_pkg::*;
#(
  parameter int width      = 1,
  parameter int n          = 4,
  parameter int srcw       = 2,
  parameter int idle_limit = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [n-1:0]         REQ_SET,
  input  logic [n*width-1:0]   REQ_VAL,
  input  logic [n-1:0]         REQ_LOCK,
  output logic [n-1:0]         GRANT,
  output logic [width-1:0]     OUT_VAL,
  output logic                 OUT_HAS,
  output logic [srcw-1:0]      OUT_SRC,
  input  logic                 OUT_RDY,
  output logic                 LOCKED
);

  localparam int              cw       = cnt_bits(idle_limit);
  localparam logic [srcw-1:0] last_idx = srcw'(n - 1);
  localparam logic [cw-1:0]   idle_max = cw'(idle_limit);

  arb_state_e       state_q, state_d;
  logic [srcw-1:0]  owner_q, owner_d;
  logic [srcw-1:0]  ptr_q, ptr_d;
  logic [cw-1:0]    idle_q, idle_d, idle_inc;
  logic [width-1:0] out_val_q, out_val_d;
  logic             out_has_q, out_has_d;
  logic [srcw-1:0]  out_src_q, out_src_d;

  logic [n-1:0]     own_mask, eligible;
  logic             accept, found, grant_vld, owner_set;
  logic [srcw-1:0]  win_idx;
  logic [width-1:0] win_val;

  function automatic logic [srcw-1:0] next_idx(input logic [srcw-1:0] i);
    return (i == last_idx) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    own_mask = '0;
    win_val  = '0;
    for (int i = 0; i < n; i++) begin
      own_mask[i] = (owner_q == srcw'(i));
      if (win_idx == srcw'(i)) win_val = REQ_VAL[i*width +: width];
    end
  end

  assign eligible  = (state_q == ST_LOCKED) ? (REQ_SET & own_mask) : REQ_SET;
  assign owner_set = |(REQ_SET & own_mask);

  rr_pick #(.n(n), .srcw(srcw)) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  assign accept    = !out_has_q || OUT_RDY;
  // Reset gates the grant so upstream never sees a transfer while held in reset.
  assign grant_vld = accept && found && RST_N;
  assign idle_inc  = idle_q + 1'b1;

  always_comb begin
    GRANT = '0;
    if (grant_vld) GRANT[win_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    idle_d    = idle_q;
    out_val_d = out_val_q;
    out_has_d = out_has_q;
    out_src_d = out_src_q;
    if (grant_vld) begin
      out_val_d = win_val;
      out_src_d = win_idx;
      out_has_d = 1'b1;
      idle_d    = '0;
      if (REQ_LOCK[win_idx]) begin
        state_d = ST_LOCKED;
        owner_d = win_idx;
      end else begin
        state_d = ST_IDLE;
        ptr_d   = next_idx(win_idx);
      end
    end else begin
      if (accept) out_has_d = 1'b0;
      if (state_q == ST_LOCKED) begin
        // A stalled but requesting owner is busy, not idle.
        if (owner_set) begin
          idle_d = '0;
        end else if (idle_limit > 0 && idle_inc == idle_max) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
          idle_d  = '0;
        end else if (idle_q != {cw{1'b1}}) begin
          idle_d = idle_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      idle_q    <= '0;
      out_val_q <= '0;
      out_has_q <= 1'b0;
      out_src_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      idle_q    <= idle_d;
      out_val_q <= out_val_d;
      out_has_q <= out_has_d;
      out_src_q <= out_src_d;
    end
  end

  assign OUT_VAL = out_val_q;
  assign OUT_HAS = out_has_q;
  assign OUT_SRC = out_src_q;
  assign LOCKED  = (state_q == ST_LOCKED);

endmodule

// File: doc/rwire_rr_arbiter.md
# rwire_rr_arbiter

Round-robin arbiter that shares one registered RWire-style output channel (value + valid) among `n` requesters. Each requester presents a wire-style `SET`/`VAL` pair. The block grants at most one per cycle, supports locked bursts, and presents the winner on a registered output with a ready/valid handshake. It sits between several rule-driven producers and a single downstream consumer, such as a shared memory-request or writeback port.

## Interface
Parameters:
- `width`, 1, payload bits per requester
- `n`, 4, number of requesters (2..8)
- `srcw`, 2, source-index width; must satisfy n <= 2**srcw
- `idle_limit`, 4, consecutive owner-idle cycles that force lock release; 0 means never release on idle

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `REQ_SET`  in  n  per-requester request valid (wire "has")
- `REQ_VAL`  in  n*width  payloads; requester i occupies bits [i*width +: width]
- `REQ_LOCK`  in  n  requester i asks to keep ownership after this transfer
- `GRANT`  out  n  one-hot or zero, combinational; requester i's payload is taken this cycle
- `OUT_VAL`  out  width  registered payload
- `OUT_HAS`  out  1  registered valid
- `OUT_SRC`  out  srcw  index of the requester that produced `OUT_VAL`
- `OUT_RDY`  in  1  consumer takes `OUT_VAL` this cycle when `OUT_HAS` is 1
- `LOCKED`  out  1  registered; 1 while in state LOCKED

## Operation
- accept = !OUT_HAS || OUT_RDY.
- State IDLE:
  - Eligible requesters are all i with REQ_SET[i].
  - Winner is the first eligible index scanning ptr, ptr+1, …, n-1, 0, …, wrapping modulo n.
- State LOCKED (owner o):
  - Only o is eligible. Other requesters get no grant even if o is silent.
- GRANT[w] = accept && a winner w exists. All other GRANT bits are 0.
- On grant:
  - OUT_VAL ← REQ_VAL slice w; OUT_SRC ← w; OUT_HAS ← 1.
  - If REQ_LOCK[w]=1: go to (or stay in) LOCKED with owner w; ptr unchanged; idle counter cleared.
  - If REQ_LOCK[w]=0: go to IDLE; ptr ← (w+1) mod n.
- If accept and there is no grant: OUT_HAS ← 0. OUT_VAL and OUT_SRC hold their values (don't-care).
- If !accept: output registers hold, and no GRANT bit is asserted.
- LOCKED idle release:
  - The idle counter (width ceil(log2(idle_limit+1)), min 1) increments each cycle REQ_SET[o]=0.
  - It clears when REQ_SET[o]=1.
  - When it reaches idle_limit (idle_limit>0), go to IDLE with ptr ← (o+1) mod n. The counter saturates, never wraps.
  - A stall (REQ_SET[o]=1, !accept) is not idle.
- OUT_RDY while OUT_HAS=0 is ignored.
- REQ_LOCK with REQ_SET=0 is ignored.

## Timing
- Grant-to-output latency: 1 cycle. GRANT is asserted in cycle t and OUT_HAS/OUT_VAL are valid from t+1.
- Throughput: 1 transfer/cycle. An OUT_RDY and a new grant in the same cycle replace the output register with no bubble.
- The GRANT path is combinational from REQ_SET, OUT_HAS, OUT_RDY and state. It has no path from REQ_VAL or REQ_LOCK.
- The state/ptr update uses REQ_LOCK sampled in the grant cycle.
- Reset (asynchronous assert, any time, including mid-burst or with OUT_HAS=1) forces:
  - OUT_HAS=0, OUT_VAL=0, OUT_SRC=0
  - state IDLE, LOCKED=0, ptr=0, idle counter=0
  - GRANT=0 while RST_N=0
- Deassertion is synchronous to `CLK` at the integration level. The first grant is possible in the first cycle after release.

## Structure
- Shared package `rwire_arb_pkg`: state encoding (IDLE=1'b0, LOCKED=1'b1) and a clog2-style constant function used for the counter width.
- One sub-module, `rr_pick`: a combinational rotate-priority picker with inputs req[n] and ptr[srcw], and outputs found and idx[srcw]. The top instantiates it once.
- The top holds the lock mask, output register, ptr and idle counter.

## Test plan
- **Basic rotation:** n=4, REQ_SET=4'b1111 held, OUT_RDY=1, LOCK=0. GRANT sequence 0001, 0010, 0100, 1000, 0001; OUT_SRC 0,1,2,3 one cycle later.
- **Backpressure:** OUT_HAS=1, OUT_RDY=0 for 3 cycles with REQ_SET=4'b0110. GRANT=0 throughout and OUT_VAL stable. After RDY=1: grant goes to requester 1 or 2 per ptr, with no lost or duplicated payload.
- **Locked burst:** requester 2 sends payloads 0xA, 0xB with LOCK=1, then 0xC with LOCK=0, while requesters 0 and 1 hold REQ_SET. Requester 2 takes 3 consecutive grants; next grant goes to 3 if requesting, else 0.
- **Idle release:** idle_limit=4; owner 1 goes silent after a LOCK=1 transfer. LOCKED stays 1 for 3 cycles and drops after the 4th idle cycle; requester 2 is granted in the following cycle.
- **Wrap and sparse:** ptr=3, REQ_SET=4'b0001. GRANT=0001 and ptr becomes 1.
- **Reset mid-burst:** assert RST_N=0 while LOCKED=1 and OUT_HAS=1. Outputs clear immediately, without waiting for a clock edge. After release with REQ_SET=4'b1111, requester 0 is granted first.
